// File: rtl/mac_ctrl_pkg.sv
// Shared types and defaults for the two-requester multiply-accumulate arbiter.
package mac_ctrl_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int WAIT_MAX_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        SEND_C,
        WAIT,
        DONE
    } state_t;

    typedef logic req_idx_t;

    function automatic logic [1:0] idx2onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mac_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the requester not granted last wins.
module rr_arb2
    import mac_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last_grant,
    input  logic       update,
    output logic [1:0] gnt
);

    // update qualifies the grant so it only reaches requesters while accepting
    always_comb begin
        gnt = 2'b00;
        if (update) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mac_arbiter.sv
// Arbitrates two requesters onto a serial a/b/c datapath and returns a*b+c with timeout.
module mac_arbiter
    import mac_ctrl_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0][DATA_W-1:0] req_a,
    input  logic [1:0][DATA_W-1:0] req_b,
    input  logic [1:0][DATA_W-1:0] req_c,
    output logic [1:0]             req_ready,
    output logic [1:0]             rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   dp_validi,
    output logic [DATA_W-1:0]      dp_data_in,
    input  logic                   dp_valido,
    input  logic [DATA_W-1:0]      dp_data_out,
    output logic                   protocol_err
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_t            state_q, state_d;
    req_idx_t          idx_q, idx_d;
    req_idx_t          last_grant_q, last_grant_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              protocol_err_q, protocol_err_d;

    logic [1:0]        gnt;
    logic              xfer;
    req_idx_t          win_idx;

    rr_arb2 u_rr_arb2 (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .update     ((state_q == IDLE) && !rst),
        .gnt        (gnt)
    );

    assign req_ready    = gnt;
    assign xfer         = |(req_valid & gnt);
    assign win_idx      = gnt[1];
    assign protocol_err = protocol_err_q;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        last_grant_d   = last_grant_q;
        a_d            = a_q;
        b_d            = b_q;
        c_d            = c_q;
        res_d          = res_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        // a result strobe outside WAIT is flagged but never steers the FSM
        protocol_err_d = protocol_err_q | (dp_valido && (state_q != WAIT));
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    idx_d        = win_idx;
                    last_grant_d = win_idx;
                    a_d          = req_a[win_idx];
                    b_d          = req_b[win_idx];
                    c_d          = req_c[win_idx];
                    state_d      = SEND_A;
                end
            end
            SEND_A: state_d = SEND_B;
            SEND_B: state_d = SEND_C;
            SEND_C: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // a result on the last allowed cycle still wins over the timeout
                if (dp_valido) begin
                    res_d   = dp_data_out;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dp_validi  = 1'b0;
        dp_data_in = '0;
        rsp_valid  = 2'b00;
        rsp_data   = '0;
        rsp_err    = 1'b0;
        if (!rst) begin
            case (state_q)
                SEND_A: begin
                    dp_validi  = 1'b1;
                    dp_data_in = a_q;
                end
                SEND_B: begin
                    dp_validi  = 1'b1;
                    dp_data_in = b_q;
                end
                SEND_C: begin
                    dp_validi  = 1'b1;
                    dp_data_in = c_q;
                end
                DONE: begin
                    rsp_valid = idx2onehot(idx_q);
                    rsp_data  = res_q;
                    rsp_err   = err_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= 1'b0;
            last_grant_q   <= 1'b1;
            a_q            <= '0;
            b_q            <= '0;
            c_q            <= '0;
            res_q          <= '0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            last_grant_q   <= last_grant_d;
            a_q            <= a_d;
            b_q            <= b_d;
            c_q            <= c_d;
            res_q          <= res_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
            protocol_err_q <= protocol_err_d;
        end
    end

endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: directed vector table, corner sequences, and a random run against a transaction model.
module tb_mac_arbiter;

    localparam int DW = 32;
    localparam int WM = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         req_valid = '0;
    logic [1:0][DW-1:0] req_a = '0, req_b = '0, req_c = '0;
    logic [1:0]         req_ready, rsp_valid;
    logic [DW-1:0]      rsp_data, dp_data_in;
    logic               rsp_err, dp_validi, protocol_err;
    logic               dp_valido = 1'b0;
    logic [DW-1:0]      dp_data_out = '0;

    always #5 clk = ~clk;

    mac_arbiter #(.DATA_W(DW), .WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .dp_validi(dp_validi), .dp_data_in(dp_data_in),
        .dp_valido(dp_valido), .dp_data_out(dp_data_out),
        .protocol_err(protocol_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // datapath model: collects three operands, answers dp_lat cycles after the last (0 = never)
    logic [DW-1:0] ops[3];
    int            ops_n  = 0;
    bit            pend   = 0;
    int            cd     = 0;
    int            dp_lat = 1;
    bit            spur   = 0;

    typedef struct {
        bit            idx;
        logic [DW-1:0] a, b, c;
        int            lat;
        logic [DW-1:0] exp_d;
        bit            exp_e;
        int            exp_off;
    } vec_t;

    vec_t vt[7];

    function automatic logic [1:0] oh(input int i);
        return (i != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic dp_tick();
        logic [DW-1:0] r;
        dp_valido   = spur;
        spur        = 0;
        dp_data_out = DW'($urandom());
        if (pend) begin
            if (cd == 0) begin
                r           = ops[0] * ops[1] + ops[2];
                dp_valido   = 1'b1;
                dp_data_out = r;
                pend        = 0;
            end else begin
                cd--;
            end
        end
        if (dp_validi === 1'b1) begin
            ops[ops_n] = dp_data_in;
            ops_n++;
            if (ops_n == 3) begin
                ops_n = 0;
                if (dp_lat > 0) begin
                    pend = 1;
                    cd   = dp_lat - 1;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        dp_tick();
    endtask

    task automatic dp_clear();
        ops_n = 0;
        pend  = 0;
    endtask

    task automatic do_reset();
        dp_clear();
        rst       = 1'b1;
        req_valid = 2'b11;
        step();
        step();
        #1;
        chk("reset.req_ready", req_ready, 2'b00);
        chk("reset.rsp_valid", rsp_valid, 2'b00);
        chk("reset.rsp_data", rsp_data, 0);
        chk("reset.rsp_err", rsp_err, 0);
        chk("reset.dp_validi", dp_validi, 0);
        chk("reset.dp_data_in", dp_data_in, 0);
        chk("reset.protocol_err", protocol_err, 0);
        dp_clear();
        rst       = 1'b0;
        req_valid = 2'b00;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int off;
        off = -1;
        step();
        req_valid         = oh(v.idx);
        req_a[v.idx]      = v.a;
        req_b[v.idx]      = v.b;
        req_c[v.idx]      = v.c;
        req_a[!v.idx]     = DW'($urandom());
        dp_lat            = v.lat;
        #1;
        chk($sformatf("%s.ready", tag), req_ready, oh(v.idx));
        step();
        req_valid = 2'b00;
        #1;
        chk($sformatf("%s.op_a", tag), {dp_validi, dp_data_in}, {1'b1, v.a});
        step();
        #1;
        chk($sformatf("%s.op_b", tag), {dp_validi, dp_data_in}, {1'b1, v.b});
        step();
        #1;
        chk($sformatf("%s.op_c", tag), {dp_validi, dp_data_in}, {1'b1, v.c});
        for (int k = 4; k <= 12; k++) begin
            step();
            #1;
            if (k == 4) chk($sformatf("%s.gap", tag), dp_validi, 0);
            if (rsp_valid != 2'b00) begin
                off = k;
                break;
            end
        end
        chk($sformatf("%s.rsp_offset", tag), off, v.exp_off);
        if (off > 0) begin
            chk($sformatf("%s.rsp_valid", tag), rsp_valid, oh(v.idx));
            chk($sformatf("%s.rsp_data", tag), rsp_data, v.exp_d);
            chk($sformatf("%s.rsp_err", tag), rsp_err, v.exp_e);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{0, 32'd3, 32'd4, 32'd5, 1, 32'd17, 0, 5};
        vt[1] = '{0, 32'hFFFF_FFFF, 32'd2, 32'd3, 1, 32'h0000_0001, 0, 5};
        vt[2] = '{1, 32'd7, 32'd6, 32'd1, 1, 32'd43, 0, 5};
        vt[3] = '{1, 32'd10, 32'd10, 32'd10, 4, 32'd110, 0, 8};
        vt[4] = '{0, 32'd1, 32'd2, 32'd3, 0, 32'd0, 1, 8};
        vt[5] = '{0, 32'h0001_0000, 32'h0001_0000, 32'd5, 2, 32'd5, 0, 6};
        vt[6] = '{1, 32'h1234_5678, 32'd0, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, 0, 7};

        do_reset();
        for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // contention: both held high, grants must alternate starting with requester 0
        begin
            int  gcnt, rcnt;
            int  g_exp[4];
            bit  last_g;
            g_exp  = '{0, 1, 0, 1};
            gcnt   = 0;
            rcnt   = 0;
            last_g = 0;
            do_reset();
            req_valid = 2'b11;
            req_a[0] = 2; req_b[0] = 3; req_c[0] = 4;
            req_a[1] = 5; req_b[1] = 5; req_c[1] = 5;
            dp_lat = 1;
            for (int k = 0; k < 40 && rcnt < 4; k++) begin
                #1;
                if (req_ready != 2'b00 && gcnt < 4) begin
                    chk($sformatf("contend.grant%0d", gcnt), req_ready, oh(g_exp[gcnt]));
                    last_g = req_ready[1];
                    gcnt++;
                end
                if (rsp_valid != 2'b00) begin
                    chk($sformatf("contend.rsp_route%0d", rcnt), rsp_valid, oh(last_g));
                    chk($sformatf("contend.rsp_data%0d", rcnt), rsp_data, last_g ? 32'd30 : 32'd10);
                    rcnt++;
                end
                if (rcnt < 4) step();
            end
            chk("contend.grants", gcnt, 4);
            chk("contend.responses", rcnt, 4);
            req_valid = 2'b00;
        end

        // spurious result strobe while idle
        spur = 1;
        step();
        #1;
        chk("spur.not_yet", protocol_err, 0);
        step();
        #1;
        chk("spur.set", protocol_err, 1);
        run_vec(vt[0], "spur_txn");
        chk("spur.sticky", protocol_err, 1);
        do_reset();

        // reset while SEND_B is on the bus
        begin
            int nrsp;
            nrsp = 0;
            step();
            req_valid = 2'b01;
            req_a[0] = 9; req_b[0] = 8; req_c[0] = 7;
            dp_lat = 1;
            step();
            req_valid = 2'b00;
            step();
            #1;
            chk("rstb.in_send_b", {dp_validi, dp_data_in}, {1'b1, 32'd8});
            rst = 1'b1;
            dp_clear();
            step();
            rst = 1'b0;
            #1;
            chk("rstb.validi_low", dp_validi, 0);
            for (int k = 0; k < 12; k++) begin
                step();
                #1;
                if (rsp_valid != 2'b00) nrsp++;
            end
            chk("rstb.no_rsp", nrsp, 0);
            run_vec(vt[2], "rstb_fresh");
        end

        // random traffic against a transaction-level model
        begin
            int            free_at, rsp_at, acc_at, lg, w, lsel, eff, kk;
            bit            ridx, re;
            logic [DW-1:0] oa, ob, oc, rd, exp_dd;
            logic [1:0]    exp_r;
            bit            exp_v;
            do_reset();
            free_at = cyc;
            rsp_at  = -1;
            acc_at  = -100;
            lg      = 1;
            ridx    = 0;
            re      = 0;
            rd      = '0;
            oa = '0; ob = '0; oc = '0;
            for (int n = 0; n < 1500; n++) begin
                step();
                req_valid = 2'($urandom_range(0, 3));
                for (int r = 0; r < 2; r++) begin
                    req_a[r] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : DW'($urandom());
                    req_b[r] = DW'($urandom());
                    req_c[r] = DW'($urandom());
                end
                #1;
                exp_r = 2'b00;
                if (cyc >= free_at && req_valid != 2'b00) begin
                    if (req_valid == 2'b01)      w = 0;
                    else if (req_valid == 2'b10) w = 1;
                    else                         w = (lg == 1) ? 0 : 1;
                    exp_r = oh(w);
                end
                chk("rand.req_ready", req_ready, exp_r);
                if (exp_r != 2'b00) begin
                    lg      = w;
                    ridx    = (w != 0);
                    acc_at  = cyc;
                    oa      = req_a[w];
                    ob      = req_b[w];
                    oc      = req_c[w];
                    lsel    = $urandom_range(0, 4);
                    dp_lat  = lsel;
                    eff     = (lsel == 0) ? WM : lsel;
                    rsp_at  = cyc + 4 + eff;
                    free_at = rsp_at + 1;
                    re      = (lsel == 0);
                    rd      = (lsel == 0) ? '0 : oa * ob + oc;
                end
                kk     = cyc - acc_at;
                exp_v  = (kk >= 1 && kk <= 3);
                exp_dd = (kk == 1) ? oa : (kk == 2) ? ob : (kk == 3) ? oc : '0;
                chk("rand.dp_bus", {dp_validi, dp_data_in}, {exp_v, exp_dd});
                chk("rand.rsp_valid", rsp_valid, (cyc == rsp_at) ? oh(ridx) : 2'b00);
                if (cyc == rsp_at) begin
                    chk("rand.rsp_data", rsp_data, rd);
                    chk("rand.rsp_err", rsp_err, re);
                end
                chk("rand.protocol_err", protocol_err, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of operands, datapath data and results.
REQ-002 Parameter WAIT_MAX, default 4, maximum WAIT-state cycles allowed for dp_valido before timeout.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; both are listed below.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  2  per-requester transaction request; bit i belongs to requester i.
REQ-007 req_a, req_b, req_c  input  2 x DATA_W each  operands of requester i; the result is a*b+c.
REQ-008 req_ready  output  2  one-hot accept strobe; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 rsp_valid  output  2  one-cycle, one-hot response pulse to the served requester.
REQ-010 rsp_data  output  DATA_W  result, valid while rsp_valid is nonzero.
REQ-011 rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-012 dp_validi  output  1  datapath input-valid.
REQ-013 dp_data_in  output  DATA_W  datapath operand bus.
REQ-014 dp_valido  input  1  datapath result-valid.
REQ-015 dp_data_out  input  DATA_W  datapath result.
REQ-016 protocol_err  output  1  sticky error flag, cleared only by rst.

Function
REQ-017 The FSM SHALL have the states IDLE, SEND_A, SEND_B, SEND_C, WAIT and DONE.
REQ-018 In IDLE, req_ready SHALL be combinational and go only to the arbitration winner; it SHALL be 0 in every other state.
REQ-019 Arbitration SHALL be round-robin.
- If only one requester is valid, it wins.
- If both are valid, the requester not granted last wins.
- last_grant resets to 1, so requester 0 wins the first contested cycle.
REQ-020 When a transfer is accepted at cycle t, the block SHALL latch a, b, c and the requester index, and move to SEND_A.
REQ-021 Operand sequence:
- t+1 (SEND_A): dp_validi=1, dp_data_in=a.
- t+2 (SEND_B): dp_validi=1, dp_data_in=b.
- t+3 (SEND_C): dp_validi=1, dp_data_in=c.
REQ-022 In every state other than SEND_A/B/C, dp_validi SHALL be 0 and dp_data_in SHALL be 0.
- Consequence: at most three consecutive validi cycles per burst.
- Consequence: at least three validi-low cycles between bursts.
REQ-023 In WAIT, a wait counter SHALL start at 0 on entry and increment each cycle.
- dp_valido=1: capture dp_data_out, set err=0, go to DONE.
- Counter reaches WAIT_MAX-1 without dp_valido: set captured data=0, err=1, go to DONE.
REQ-024 A nominal datapath asserts dp_valido at t+4, the first WAIT cycle; the block SHALL accept it there with no extra latency.
REQ-025 In DONE:
- rsp_valid[idx]=1 for exactly one cycle.
- rsp_data shows the captured result; rsp_err shows the captured err.
- Next state is IDLE.
- Nominal timing: accept at t, response at t+5, next accept possible at t+6.
REQ-026 rsp_data SHALL be passed through from dp_data_out unchanged; the datapath owns the a*b+c mod 2^DATA_W truncation.
REQ-027 dp_valido=1 in any state other than WAIT SHALL set protocol_err and SHALL NOT change the FSM.
REQ-028 A request deasserted before acceptance SHALL be dropped silently; requests SHALL NOT be queued.
REQ-029 A new req_valid during a transaction SHALL only be considered once the FSM returns to IDLE.

Reset
REQ-030 While rst=1, on the clock edge the block SHALL enter IDLE and abandon any in-flight transaction with no response.
REQ-031 Reset values: req_ready=0 while rst is high; rsp_valid=0; rsp_data=0; rsp_err=0; dp_validi=0; dp_data_in=0; protocol_err=0; last_grant=1; wait counter=0.
REQ-032 After a reset mid-burst, dp_validi SHALL be 0 in the first cycle after rst deasserts.

Structure
REQ-033 A shared package mac_ctrl_pkg SHALL hold:
- the FSM state enum type;
- DATA_W and WAIT_MAX defaults;
- the requester index typedef.
REQ-034 Round-robin selection SHALL be a sub-module rr_arb2 with inputs req[1:0], last_grant and update, and output a one-hot gnt.

Verification
REQ-035 Single request: requester 0 sends a=3, b=4, c=5 with a model datapath.
- dp_data_in = 3, 4, 5 on t+1..t+3.
- rsp_valid=01 at t+5 with rsp_data=17 and rsp_err=0.
REQ-036 Contention: both requesters are valid continuously.
- Grants alternate 0, 1, 0, 1.
- Responses are routed to the matching rsp_valid bit.
REQ-037 Timeout: datapath model never asserts dp_valido.
- With WAIT_MAX=4, rsp_err=1 and rsp_data=0 arrive at t+8.
REQ-038 Spurious dp_valido pulse in IDLE:
- protocol_err goes to 1 and stays 1 until rst.
- The next transaction still completes correctly.
REQ-039 rst asserted at SEND_B:
- dp_validi=0 the next cycle.
- No rsp_valid is produced.
- A fresh request is accepted normally.
REQ-040 Wrap-around: a=0xFFFFFFFF, b=2, c=3 -> rsp_data=0x00000001.
